seven_seg_scan_driver: RTL and testbench

// - Downstream display stage of the stopwatch. Consumes the packed BCD digit outputs of the digit-counter chain.
// - Drives a common-anode, time-multiplexed 7-segment display: one digit lit at a time, round-robin scan.
// - Inserts blank guard cycles at each digit change (anti-ghosting) and blanks leading zeros.

---
 rtl/seven_seg_scan_driver_pkg.sv | 25 ++
 rtl/seven_seg_scan_driver_bcd_to_seg.sv | 34 +++
 rtl/seven_seg_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 125 ++++++++++++
 4 files changed

// File: rtl/seven_seg_scan_driver_pkg.sv
// rtl/seven_seg_scan_driver_pkg.sv - shared constants for the seven-segment scan driver
// Purpose: segment patterns (active-low {g,f,e,d,c,b,a}) and scan FSM state encodings.
// Ports: none (package).
package seven_seg_scan_driver_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  // Non-BCD nibble: shows a dash so an upstream counter fault is visible.
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seven_seg_scan_driver_bcd_to_seg.sv
// rtl/seven_seg_scan_driver_bcd_to_seg.sv - combinational BCD to 7-segment decoder
// Purpose: decode one BCD nibble to active-low segments, with a forced-blank input.
// Ports:
//   bcd    in  4  BCD digit (10..15 decode to a dash)
//   blank  in  1  1 = all segments off regardless of bcd
//   seg_n  out 7  active-low segments {g,f,e,d,c,b,a}
module seven_seg_scan_driver_bcd_to_seg
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    if (!blank) begin
      case (bcd)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed common-anode 7-segment scan driver
// Purpose: round-robin digit scan with blank guard cycles at each digit change
//          and optional leading-zero blanking. All outputs registered.
// Ports:
//   clk        in  1             system clock
//   rst        in  1             asynchronous active-high reset
//   enable     in  1             0 = display dark, scan frozen
//   digits_in  in  4*NUM_DIGITS  packed BCD, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in      in  NUM_DIGITS    decimal point request per digit, 1 = lit
//   seg_n      out 7             active-low segments {g,f,e,d,c,b,a}
//   dp_n       out 1             active-low decimal point
//   an_n       out NUM_DIGITS    active-low anode enables, at most one low
//   digit_idx  out clog2(N)      index of the current slot
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned REFRESH_HZ    = 1000,
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  output logic [6:0]                    seg_n,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  import seven_seg_scan_driver_pkg::*;

  localparam int unsigned DIV   = CLK_HZ / REFRESH_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned GRD_W = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  scan_state_e            state_q, state_d;
  logic [PRE_W-1:0]       prescaler_q, prescaler_d;
  logic [GRD_W-1:0]       guard_cnt_q, guard_cnt_d;
  logic [IDX_W-1:0]       digit_idx_q, digit_idx_d;
  logic [6:0]             seg_n_q, seg_n_d;
  logic                   dp_n_q, dp_n_d;
  logic [NUM_DIGITS-1:0]  an_n_q, an_n_d;

  logic [NUM_DIGITS-1:0]  lead_blank;
  logic                   zero_run;
  logic [3:0]             cur_bcd;
  logic                   cur_dp;
  logic                   cur_blank;
  logic [6:0]             dec_seg_n;
  logic                   tick;
  logic                   guard_done;

  // A digit is a leading zero when it and every more-significant digit are 0.
  // Digit 0 is left out so a zero value still shows "0".
  always_comb begin
    zero_run   = 1'b1;
    lead_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (digits_in[4*i +: 4] == 4'd0);
      if (i > 0) begin
        lead_blank[i] = zero_run & BLANK_LEADING;
      end
    end
  end

  always_comb begin
    cur_bcd   = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx_q == IDX_W'(i)) begin
        cur_bcd   = digits_in[4*i +: 4];
        cur_dp    = dp_in[i];
        cur_blank = lead_blank[i];
      end
    end
  end

  seven_seg_scan_driver_bcd_to_seg u_dec (
    .bcd   (cur_bcd),
    .blank (cur_blank),
    .seg_n (dec_seg_n)
  );

  assign tick       = (prescaler_q == PRE_W'(DIV - 1));
  assign guard_done = (guard_cnt_q == GRD_W'(GUARD_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    guard_cnt_d = guard_cnt_q;
    digit_idx_d = digit_idx_q;
    seg_n_d     = seg_n_q;
    dp_n_d      = dp_n_q;
    an_n_d      = an_n_q;

    if (!enable) begin
      // Freeze the scan position; re-enable replays a full guard on this digit.
      state_d     = ST_GUARD;
      guard_cnt_d = '0;
      seg_n_d     = SEG_OFF;
      dp_n_d      = 1'b1;
      an_n_d      = '1;
    end else if (tick) begin
      // Slot boundary wins over any FSM activity.
      prescaler_d = '0;
      digit_idx_d = (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
      state_d     = ST_GUARD;
      guard_cnt_d = '0;
      seg_n_d     = SEG_OFF;
      dp_n_d      = 1'b1;
      an_n_d      = '1;
    end else begin
      prescaler_d = prescaler_q + 1'b1;
      case (state_q)
        ST_GUARD: begin
          guard_cnt_d = guard_cnt_q + 1'b1;
          if (guard_done) begin
            // Inputs are sampled only here; the digit then stays frozen for the slot.
            state_d = ST_SHOW;
            seg_n_d = dec_seg_n;
            dp_n_d  = ~cur_dp;
            an_n_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
          end
        end
        ST_SHOW: begin
        end
        default: begin
          state_d = ST_GUARD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_GUARD;
      prescaler_q <= '0;
      guard_cnt_q <= '0;
      digit_idx_q <= '0;
      seg_n_q     <= SEG_OFF;
      dp_n_q      <= 1'b1;
      an_n_q      <= '1;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      guard_cnt_q <= guard_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_n_q     <= seg_n_d;
      dp_n_q      <= dp_n_d;
      an_n_q      <= an_n_d;
    end
  end

  assign seg_n     = seg_n_q;
  assign dp_n      = dp_n_q;
  assign an_n      = an_n_q;
  assign digit_idx = digit_idx_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n, seg_n_nb;
  logic        dp_n, dp_n_nb;
  logic [3:0]  an_n, an_n_nb;
  logic [1:0]  digit_idx, digit_idx_nb;

  int errors = 0;
  int checks = 0;
  int k = 0;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(100), .GUARD_CYCLES(2), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .digit_idx(digit_idx)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_HZ(1000), .REFRESH_HZ(100), .GUARD_CYCLES(2), .BLANK_LEADING(1'b0)
  ) dut_nb (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
    .seg_n(seg_n_nb), .dp_n(dp_n_nb), .an_n(an_n_nb), .digit_idx(digit_idx_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp, input logic [1:0] e_idx);
    chk({tag, ".an_n"},  32'(an_n),      32'(e_an));
    chk({tag, ".seg_n"}, 32'(seg_n),     32'(e_seg));
    chk({tag, ".dp_n"},  32'(dp_n),      32'(e_dp));
    chk({tag, ".idx"},   32'(digit_idx), 32'(e_idx));
  endtask

  // Advance to k edges after the most recent reset release, sampling 1 time unit after the edge.
  task automatic go_to(input int target);
    while (k < target) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    digits_in = 16'h1234;
    dp_in     = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    chk_slot("reset", 4'b1111, 7'h7F, 1'b1, 2'd0);
    rst = 1'b0;
    k   = 0;

    go_to(1);  chk_slot("guard0", 4'b1111, 7'h7F, 1'b1, 2'd0);
    go_to(2);  chk_slot("show_d0_4", 4'b1110, 7'b0011001, 1'b1, 2'd0);
    go_to(9);  chk_slot("last_lit_d0", 4'b1110, 7'b0011001, 1'b1, 2'd0);
    go_to(10); chk_slot("tick_d1", 4'b1111, 7'h7F, 1'b1, 2'd1);
    go_to(11); chk_slot("guard_d1", 4'b1111, 7'h7F, 1'b1, 2'd1);
    go_to(12); chk_slot("show_d1_3", 4'b1101, 7'b0110000, 1'b1, 2'd1);
    go_to(22); chk_slot("show_d2_2dp", 4'b1011, 7'b0100100, 1'b0, 2'd2);
    go_to(32); chk_slot("show_d3_1", 4'b0111, 7'b1111001, 1'b1, 2'd3);
    go_to(40); chk_slot("wrap_idx0", 4'b1111, 7'h7F, 1'b1, 2'd0);
    go_to(42); chk_slot("show_d0_again", 4'b1110, 7'b0011001, 1'b1, 2'd0);

    digits_in = 16'h0005;
    go_to(45); chk_slot("midshow_hold", 4'b1110, 7'b0011001, 1'b1, 2'd0);
    go_to(52); chk_slot("lz_d1", 4'b1101, 7'h7F, 1'b1, 2'd1);
    chk("nb_d1_zero", 32'(seg_n_nb), 32'(7'b1000000));
    chk("nb_d1_an", 32'(an_n_nb), 32'(4'b1101));
    go_to(62); chk_slot("lz_d2_dp", 4'b1011, 7'h7F, 1'b0, 2'd2);
    go_to(72); chk_slot("lz_d3", 4'b0111, 7'h7F, 1'b1, 2'd3);
    chk("nb_d3_zero", 32'(seg_n_nb), 32'(7'b1000000));
    go_to(82); chk_slot("show_d0_5", 4'b1110, 7'b0010010, 1'b1, 2'd0);

    digits_in = 16'h0000;
    go_to(92); chk_slot("all0_d1", 4'b1101, 7'h7F, 1'b1, 2'd1);
    go_to(122); chk_slot("all0_d0", 4'b1110, 7'b1000000, 1'b1, 2'd0);
    chk("nb_all0_d0", 32'(seg_n_nb), 32'(7'b1000000));

    digits_in = 16'h00C0;
    go_to(132); chk_slot("dash_d1", 4'b1101, 7'b0111111, 1'b1, 2'd1);
    go_to(142); chk_slot("lz_d2_c0", 4'b1011, 7'h7F, 1'b0, 2'd2);
    go_to(144);
    enable = 1'b0;
    go_to(145); chk_slot("disable_dark", 4'b1111, 7'h7F, 1'b1, 2'd2);
    go_to(149); chk_slot("disable_hold", 4'b1111, 7'h7F, 1'b1, 2'd2);
    enable = 1'b1;
    go_to(150); chk_slot("reen_guard", 4'b1111, 7'h7F, 1'b1, 2'd2);
    go_to(151); chk_slot("reen_show", 4'b1011, 7'h7F, 1'b0, 2'd2);
    go_to(154); chk_slot("reen_last", 4'b1011, 7'h7F, 1'b0, 2'd2);
    go_to(155); chk_slot("reen_tick", 4'b1111, 7'h7F, 1'b1, 2'd3);
    go_to(158); chk_slot("show_d3_c0", 4'b0111, 7'h7F, 1'b1, 2'd3);

    rst = 1'b1;
    #1;
    chk_slot("async_rst", 4'b1111, 7'h7F, 1'b1, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    k   = 0;
    go_to(1); chk_slot("rst2_guard", 4'b1111, 7'h7F, 1'b1, 2'd0);
    go_to(2); chk_slot("rst2_show_d0", 4'b1110, 7'b1000000, 1'b1, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
